// File: rtl/vec_decode_cfg.sv
// Vector decode/config front end: runs vsetvl* against the vl/vtype CSRs and
// issues arithmetic micro-ops via a one-entry register. Optional: VEC_DEC_FRAC_LMUL_EN.
module vec_decode_cfg #(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int ELEN = 32
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            inst_valid_i,
    output logic            inst_ready_o,
    input  logic [XLEN-1:0] vec_inst_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            is_vec_o,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            illegal_o,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [4:0]      dec_vd_o,
    output logic [4:0]      dec_vs1_o,
    output logic [4:0]      dec_vs2_o,
    output logic [5:0]      dec_func6_o,
    output logic [2:0]      dec_func3_o,
    output logic            dec_vm_o,
    output logic [XLEN-1:0] dec_scalar_o,
    output logic [XLEN-1:0] dec_vl_o,
    output logic [2:0]      dec_sew_o,
    output logic [XLEN-1:0] vl_o,
    output logic [XLEN-1:0] vtype_o
);
    localparam logic [6:0]      OPC_V       = 7'h57;
    localparam logic [2:0]      SEW_LOG_MAX = 3'($clog2(ELEN / 8));
    localparam logic [XLEN-1:0] VILL_VTYPE  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] VLEN_BYTES  = XLEN'(VLEN / 8);

    logic [XLEN-1:0] r_vl, r_vtype, r_wb_data, r_dec_scalar, r_dec_vl;
    logic [4:0]      r_wb_rd, r_dec_vd, r_dec_vs1, r_dec_vs2;
    logic [5:0]      r_dec_func6;
    logic [2:0]      r_dec_func3, r_dec_sew;
    logic            r_wb_valid, r_illegal, r_dec_valid, r_dec_vm;

    logic [2:0]      w_f3, w_vlmul, w_vsew;
    logic [4:0]      w_rs1_idx, w_rd;
    logic            w_is_vec, w_arith, w_cfg, w_vsetvli, w_vsetivli, w_vsetvl, w_cfg_ok;
    logic            w_accept, w_issue, w_do_cfg, w_illegal, w_vill;
    logic [XLEN-1:0] w_new_vtype, w_vlmax, w_avl, w_new_vl, w_scalar;

    assign w_f3      = vec_inst_i[14:12];
    assign w_rs1_idx = vec_inst_i[19:15];
    assign w_rd      = vec_inst_i[11:7];
    assign w_is_vec  = (vec_inst_i[6:0] == OPC_V);
    assign w_arith   = w_is_vec && (w_f3 == 3'b000 || w_f3 == 3'b010 || w_f3 == 3'b011 ||
                                    w_f3 == 3'b100 || w_f3 == 3'b110);
    assign w_cfg      = w_is_vec && (w_f3 == 3'b111);
    assign w_vsetvli  = w_cfg && !vec_inst_i[31];
    assign w_vsetivli = w_cfg && (vec_inst_i[31:30] == 2'b11);
    assign w_vsetvl   = w_cfg && (vec_inst_i[31:25] == 7'b1000000);
    assign w_cfg_ok   = w_vsetvli || w_vsetivli || w_vsetvl;

    assign inst_ready_o = !r_dec_valid || dec_ready_i;
    assign w_accept     = inst_valid_i && inst_ready_o;
    assign w_issue      = w_accept && w_arith && !r_vtype[XLEN-1];
    assign w_do_cfg     = w_accept && w_cfg_ok;
    assign w_illegal    = w_accept && (!w_is_vec || (w_cfg ? !w_cfg_ok : !w_arith) ||
                                       (w_arith && r_vtype[XLEN-1]));

    always_comb begin
        w_new_vtype = XLEN'(vec_inst_i[30:20]);
        if (w_vsetvl)
            w_new_vtype = rs2_i;
        else if (w_vsetivli)
            w_new_vtype = XLEN'(vec_inst_i[29:20]);
    end

    assign w_vlmul = w_new_vtype[2:0];
    assign w_vsew  = w_new_vtype[5:3];

`ifdef VEC_DEC_FRAC_LMUL_EN
    logic [2:0] w_frac_sh;
    assign w_frac_sh = 3'(4'd8 - {1'b0, w_vlmul});
`endif

    // VLMAX is built from shifts of VLEN/8; any vtype it cannot represent flags vill.
    always_comb begin
        w_vill  = 1'b0;
        w_vlmax = '0;
        if (|w_new_vtype[XLEN-1:8] || w_vlmul == 3'b100) begin
            w_vill = 1'b1;
        end else if (!w_vlmul[2]) begin
            if (w_vsew > SEW_LOG_MAX)
                w_vill = 1'b1;
            else
                w_vlmax = (VLEN_BYTES >> w_vsew) << w_vlmul;
        end else begin
`ifdef VEC_DEC_FRAC_LMUL_EN
            if (({1'b0, w_vsew} + {1'b0, w_frac_sh}) > {1'b0, SEW_LOG_MAX})
                w_vill = 1'b1;
            else
                w_vlmax = (VLEN_BYTES >> w_vsew) >> w_frac_sh;
`else
            w_vill = 1'b1;
`endif
        end
    end

    always_comb begin
        if (w_vsetivli)
            w_avl = XLEN'(w_rs1_idx);
        else if (w_rs1_idx != 5'd0)
            w_avl = rs1_i;
        else if (w_rd != 5'd0)
            w_avl = '1;
        else
            w_avl = r_vl;
    end

    assign w_new_vl = w_vill ? '0 : ((w_avl < w_vlmax) ? w_avl : w_vlmax);

    always_comb begin
        case (w_f3)
            3'b100, 3'b110: w_scalar = rs1_i;
            3'b011:         w_scalar = {{(XLEN-5){vec_inst_i[19]}}, vec_inst_i[19:15]};
            default:        w_scalar = '0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_vl         <= '0;
            r_vtype      <= VILL_VTYPE;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_illegal    <= 1'b0;
            r_dec_valid  <= 1'b0;
            r_dec_vd     <= '0;
            r_dec_vs1    <= '0;
            r_dec_vs2    <= '0;
            r_dec_func6  <= '0;
            r_dec_func3  <= '0;
            r_dec_vm     <= 1'b0;
            r_dec_scalar <= '0;
            r_dec_vl     <= '0;
            r_dec_sew    <= '0;
        end else begin
            r_wb_valid <= w_do_cfg;
            r_illegal  <= w_illegal;
            if (w_do_cfg) begin
                r_vl      <= w_new_vl;
                r_vtype   <= w_vill ? VILL_VTYPE : w_new_vtype;
                r_wb_rd   <= w_rd;
                r_wb_data <= w_new_vl;
            end
            // The vl/vsew snapshot is taken here so a later vset cannot touch a held op.
            if (w_issue) begin
                r_dec_valid  <= 1'b1;
                r_dec_vd     <= w_rd;
                r_dec_vs1    <= w_rs1_idx;
                r_dec_vs2    <= vec_inst_i[24:20];
                r_dec_func6  <= vec_inst_i[31:26];
                r_dec_func3  <= w_f3;
                r_dec_vm     <= vec_inst_i[25];
                r_dec_scalar <= w_scalar;
                r_dec_vl     <= r_vl;
                r_dec_sew    <= r_vtype[5:3];
            end else if (r_dec_valid && dec_ready_i) begin
                r_dec_valid <= 1'b0;
            end
        end
    end

    assign is_vec_o     = w_is_vec;
    assign wb_valid_o   = r_wb_valid;
    assign wb_rd_o      = r_wb_rd;
    assign wb_data_o    = r_wb_data;
    assign illegal_o    = r_illegal;
    assign dec_valid_o  = r_dec_valid;
    assign dec_vd_o     = r_dec_vd;
    assign dec_vs1_o    = r_dec_vs1;
    assign dec_vs2_o    = r_dec_vs2;
    assign dec_func6_o  = r_dec_func6;
    assign dec_func3_o  = r_dec_func3;
    assign dec_vm_o     = r_dec_vm;
    assign dec_scalar_o = r_dec_scalar;
    assign dec_vl_o     = r_dec_vl;
    assign dec_sew_o    = r_dec_sew;
    assign vl_o         = r_vl;
    assign vtype_o      = r_vtype;
endmodule

// File: tb/tb_vec_decode_cfg.sv
// Bench for vec_decode_cfg: table of vset vectors, hand-written handshake/reset
// sequences, then random traffic against an arithmetic model of the vset rules.
module tb_vec_decode_cfg;
    localparam int XLEN = 32;
    localparam int VLEN = 512;
    localparam int ELEN = 32;
    localparam logic [31:0] VILL = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        inst_valid_i, inst_ready_o, dec_ready_i, is_vec_o;
    logic [31:0] vec_inst_i, rs1_i, rs2_i;
    logic        wb_valid_o, illegal_o, dec_valid_o, dec_vm_o;
    logic [4:0]  wb_rd_o, dec_vd_o, dec_vs1_o, dec_vs2_o;
    logic [31:0] wb_data_o, dec_scalar_o, dec_vl_o, vl_o, vtype_o;
    logic [5:0]  dec_func6_o;
    logic [2:0]  dec_func3_o, dec_sew_o;

    always #5 clk = ~clk;

    vec_decode_cfg #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk(clk), .n_rst(n_rst),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .vec_inst_i(vec_inst_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .is_vec_o(is_vec_o),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .illegal_o(illegal_o),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_vd_o(dec_vd_o), .dec_vs1_o(dec_vs1_o), .dec_vs2_o(dec_vs2_o),
        .dec_func6_o(dec_func6_o), .dec_func3_o(dec_func3_o), .dec_vm_o(dec_vm_o),
        .dec_scalar_o(dec_scalar_o), .dec_vl_o(dec_vl_o), .dec_sew_o(dec_sew_o),
        .vl_o(vl_o), .vtype_o(vtype_o)
    );

    typedef struct packed {
        logic [4:0]  vd, vs1, vs2;
        logic [5:0]  f6;
        logic [2:0]  f3;
        logic        vm;
        logic [31:0] scalar, vl;
        logic [2:0]  sew;
    } uop_t;

    typedef struct {
        string       name;
        logic [31:0] inst, rs1, rs2, vl, vtype;
        logic [4:0]  rd;
    } cfg_vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] f_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] f_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                               input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] f_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
    endfunction
    function automatic logic [31:0] f_arith(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                            input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd);
        return {f6, vm, vs2, vs1, f3, vd, 7'h57};
    endfunction

    // Reference for vset*: LMUL as a fraction, VLMAX = VLEN*LMUL/SEW by division.
    function automatic void model_cfg(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                                      input logic [31:0] cur_vl, output bit form_ok,
                                      output logic [31:0] nvl, output logic [31:0] nvt);
        logic [31:0] vt;
        longint avl, vlmax;
        int sew, lnum, lden;
        bit bad;
        form_ok = 1;
        if (!inst[31])                      vt = {21'b0, inst[30:20]};
        else if (inst[31:30] == 2'b11)      vt = {22'b0, inst[29:20]};
        else if (inst[31:25] == 7'b1000000) vt = r2;
        else begin form_ok = 0; vt = '0; end
        sew  = 8 << vt[5:3];
        bad  = (vt[31:8] != 0) || (sew > ELEN);
        lnum = 1;
        lden = 1;
        case (vt[2:0])
            3'd0, 3'd1, 3'd2, 3'd3: lnum = 1 << vt[2:0];
            3'd4: bad = 1;
            default: begin
`ifdef VEC_DEC_FRAC_LMUL_EN
                lden = 1 << (8 - int'(vt[2:0]));
                if (sew > ELEN / lden) bad = 1;
`else
                bad = 1;
`endif
            end
        endcase
        vlmax = longint'(VLEN) * lnum / (longint'(sew) * lden);
        if (inst[31:30] == 2'b11)  avl = longint'(inst[19:15]);
        else if (inst[19:15] != 0) avl = longint'(r1);
        else if (inst[11:7] != 0)  avl = 64'hFFFF_FFFF;
        else                       avl = longint'(cur_vl);
        nvl = bad ? 32'd0 : 32'((avl < vlmax) ? avl : vlmax);
        nvt = bad ? VILL : vt;
    endfunction

    task automatic do_inst(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2);
        inst_valid_i = 1'b1; vec_inst_i = inst; rs1_i = r1; rs2_i = r2;
        step();
        inst_valid_i = 1'b0;
    endtask

    cfg_vec_t    tbl [12];
    uop_t        q [$];
    uop_t        exp_u, act_u;
    logic [31:0] m_vl, m_vtype, nvl, nvt, ri, r1v, r2v;
    logic [31:0] exp_wb_data;
    logic [4:0]  exp_wb_rd, rd, rs1f;
    logic [10:0] zimm;
    logic [2:0]  f3;
    logic [2:0]  f3s [5];
    logic        exp_wb, exp_ill, acc, rdy;
    bit          fok;
    int          cls;

    initial begin
        inst_valid_i = 0; vec_inst_i = 0; rs1_i = 0; rs2_i = 0; dec_ready_i = 1;
        f3s = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6};
        tbl[0]  = '{"e32m1_rs1",  f_vsetvli(5'd1, 5'd5, 11'h010),  32'd100, 32'd0,    32'd16,  32'h10, 5'd1};
        tbl[1]  = '{"e8m8_max",   f_vsetvli(5'd1, 5'd0, 11'h003),  32'd0,   32'd0,    32'd512, 32'h03, 5'd1};
        tbl[2]  = '{"keep_vl",    f_vsetvli(5'd0, 5'd0, 11'h013),  32'd0,   32'd0,    32'd128, 32'h13, 5'd0};
        tbl[3]  = '{"ivli_e16m2", f_vsetivli(5'd2, 5'd5, 10'h009), 32'd0,   32'd0,    32'd5,   32'h09, 5'd2};
        tbl[4]  = '{"vsetvl_e64", f_vsetvl(5'd3, 5'd4, 5'd6),      32'd50,  32'h18,   32'd0,   VILL,   5'd3};
        tbl[5]  = '{"e8m4_tama",  f_vsetvli(5'd4, 5'd7, 11'h0C2),  32'd1000, 32'd0,   32'd256, 32'hC2, 5'd4};
        tbl[6]  = '{"lmul_rsvd",  f_vsetvli(5'd5, 5'd0, 11'h00C), 32'd0,   32'd0,    32'd0,   VILL,   5'd5};
        tbl[7]  = '{"rsvd_bit8",  f_vsetvli(5'd6, 5'd0, 11'h110), 32'd0,   32'd0,    32'd0,   VILL,   5'd6};
        tbl[8]  = '{"ivli_31",    f_vsetivli(5'd7, 5'd31, 10'h000), 32'd0,  32'd0,    32'd31,  32'h00, 5'd7};
`ifdef VEC_DEC_FRAC_LMUL_EN
        tbl[9]  = '{"mf2",        f_vsetvli(5'd8, 5'd0, 11'h007), 32'd0,   32'd0,    32'd32,  32'h07, 5'd8};
`else
        tbl[9]  = '{"mf2",        f_vsetvli(5'd8, 5'd0, 11'h007), 32'd0,   32'd0,    32'd0,   VILL,   5'd8};
`endif
        tbl[10] = '{"vsetvl_m2",  f_vsetvl(5'd9, 5'd10, 5'd11),    32'd1,   32'h11,   32'd1,   32'h11, 5'd9};
        tbl[11] = '{"keep_vl_1",  f_vsetvli(5'd0, 5'd0, 11'h010), 32'd0,   32'd0,    32'd1,   32'h10, 5'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vl", vl_o, 0);
        chk("rst_vtype", vtype_o, VILL);
        chk("rst_dec_valid", dec_valid_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_ready", inst_ready_o, 1);
        #2 n_rst = 1'b1;
        step();

        // vill=1: arithmetic is rejected; non-vector opcode is rejected
        do_inst(f_arith(6'd0, 1'b1, 5'd2, 5'd3, 3'b000, 5'd4), 0, 0);
        chk("vill_op_illegal", illegal_o, 1);
        chk("vill_op_no_issue", dec_valid_o, 0);
        vec_inst_i = 32'h0000_0033; inst_valid_i = 1'b1;
        #1 chk("nonvec_is_vec", is_vec_o, 0);
        step();
        inst_valid_i = 1'b0;
        chk("nonvec_illegal", illegal_o, 1);
        chk("nonvec_vtype", vtype_o, VILL);
        step();
        chk("illegal_pulse_end", illegal_o, 0);

        // Table of configuration instructions
        for (int i = 0; i < 12; i++) begin
            inst_valid_i = 1'b1; vec_inst_i = tbl[i].inst; rs1_i = tbl[i].rs1; rs2_i = tbl[i].rs2;
            #1 chk({tbl[i].name, "_is_vec"}, is_vec_o, 1);
            step();
            inst_valid_i = 1'b0;
            chk({tbl[i].name, "_vl"}, vl_o, tbl[i].vl);
            chk({tbl[i].name, "_vtype"}, vtype_o, tbl[i].vtype);
            chk({tbl[i].name, "_wb_valid"}, wb_valid_o, 1);
            chk({tbl[i].name, "_wb_rd"}, wb_rd_o, tbl[i].rd);
            chk({tbl[i].name, "_wb_data"}, wb_data_o, tbl[i].vl);
            step();
            chk({tbl[i].name, "_wb_pulse"}, wb_valid_o, 0);
        end

        // Backpressure: held op keeps its vl snapshot while a vset waits behind it
        do_inst(f_vsetvli(5'd1, 5'd5, 11'h010), 32'd100, 0);
        chk("bp_vl16", vl_o, 16);
        dec_ready_i = 1'b0;
        inst_valid_i = 1'b1; vec_inst_i = f_arith(6'd0, 1'b1, 5'd3, 5'd5, 3'b100, 5'd4); rs1_i = 7;
        #1 chk("bp_ready_empty", inst_ready_o, 1);
        step();
        vec_inst_i = f_vsetivli(5'd0, 5'd3, 10'h010); rs1_i = 0;
        chk("bp_dec_valid", dec_valid_o, 1);
        chk("bp_scalar", dec_scalar_o, 7);
        chk("bp_dec_vl", dec_vl_o, 16);
        chk("bp_dec_sew", dec_sew_o, 2);
        chk("bp_dec_vd", dec_vd_o, 4);
        chk("bp_func3", dec_func3_o, 4);
        chk("bp_ready_held", inst_ready_o, 0);
        step();
        chk("bp_still_held", dec_valid_o, 1);
        chk("bp_vl_unchanged", vl_o, 16);
        chk("bp_no_wb", wb_valid_o, 0);
        dec_ready_i = 1'b1;
        #1 chk("bp_ready_release", inst_ready_o, 1);
        chk("bp_dec_vl_release", dec_vl_o, 16);
        step();
        inst_valid_i = 1'b0;
        chk("bp_drained", dec_valid_o, 0);
        chk("bp_vl3", vl_o, 3);
        chk("bp_wb", wb_valid_o, 1);
        chk("bp_wb_data", wb_data_o, 3);

        // Asynchronous reset with a held op, then with a pending wb pulse
        dec_ready_i = 1'b0;
        do_inst(f_arith(6'd5, 1'b0, 5'd1, 5'd2, 3'b011, 5'd9), 0, 0);
        chk("ar_held", dec_valid_o, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("ar_dec_valid", dec_valid_o, 0);
        chk("ar_dec_vl", dec_vl_o, 0);
        chk("ar_dec_func6", dec_func6_o, 0);
        chk("ar_vl", vl_o, 0);
        chk("ar_vtype", vtype_o, VILL);
        chk("ar_ready", inst_ready_o, 1);
        dec_ready_i = 1'b1;
        #1 n_rst = 1'b1;
        step();
        do_inst(f_vsetvli(5'd3, 5'd0, 11'h000), 0, 0);
        chk("ar2_wb_pre", wb_valid_o, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("ar2_wb", wb_valid_o, 0);
        chk("ar2_wb_data", wb_data_o, 0);
        chk("ar2_wb_rd", wb_rd_o, 0);
        chk("ar2_vl", vl_o, 0);
        #1 n_rst = 1'b1;
        step();

        // Random traffic against the model
        m_vl = 0; m_vtype = VILL; exp_wb = 0; exp_ill = 0; exp_wb_rd = 0; exp_wb_data = 0;
        for (int c = 0; c < 400; c++) begin
            chk("r_vl", vl_o, m_vl);
            chk("r_vtype", vtype_o, m_vtype);
            chk("r_wb_valid", wb_valid_o, exp_wb);
            if (exp_wb) begin
                chk("r_wb_rd", wb_rd_o, exp_wb_rd);
                chk("r_wb_data", wb_data_o, exp_wb_data);
            end
            chk("r_illegal", illegal_o, exp_ill);
            chk("r_dec_valid", dec_valid_o, q.size() != 0);
            if (q.size() != 0 && dec_valid_o) begin
                act_u = '{dec_vd_o, dec_vs1_o, dec_vs2_o, dec_func6_o, dec_func3_o, dec_vm_o,
                          dec_scalar_o, dec_vl_o, dec_sew_o};
                chk("r_uop", act_u, q[0]);
            end

            cls  = $urandom_range(0, 11);
            r1v  = $urandom_range(0, 1) ? 32'($urandom_range(0, 600)) : $urandom();
            rd   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom());
            rs1f = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom());
            zimm = {($urandom_range(0, 9) == 0) ? 3'($urandom()) : 3'd0, 2'($urandom()),
                    ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3))};
            r2v  = 32'(zimm);
            if ($urandom_range(0, 9) == 0) r2v = r2v | (32'd1 << $urandom_range(8, 31));
            ri   = $urandom();
            case (cls)
                0: if (ri[6:0] == 7'h57) ri[0] = 1'b0;
                1: ri = f_arith(6'($urandom()), 1'($urandom()), 5'($urandom()), rs1f,
                                $urandom_range(0, 1) ? 3'd1 : 3'd5, rd);
                7, 8: ri = f_vsetvli(rd, rs1f, zimm);
                9:  ri = f_vsetivli(rd, rs1f, zimm[9:0]);
                10: ri = f_vsetvl(rd, rs1f, 5'($urandom()));
                11: ri = {2'b10, 5'($urandom_range(1, 31)), 5'($urandom()), rs1f, 3'b111, rd, 7'h57};
                default: ri = f_arith(6'($urandom()), 1'($urandom()), 5'($urandom()), rs1f,
                                      f3s[$urandom_range(0, 4)], rd);
            endcase
            inst_valid_i = ($urandom_range(0, 4) != 0);
            vec_inst_i = ri; rs1_i = r1v; rs2_i = r2v;
            dec_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            rdy = (q.size() == 0) || dec_ready_i;
            chk("r_ready", inst_ready_o, rdy);
            chk("r_is_vec", is_vec_o, ri[6:0] == 7'h57);

            acc = inst_valid_i && rdy;
            if (q.size() != 0 && dec_ready_i) void'(q.pop_front());
            exp_wb = 0; exp_ill = 0;
            if (acc) begin
                f3 = ri[14:12];
                if (ri[6:0] != 7'h57) begin
                    exp_ill = 1;
                end else if (f3 == 3'b111) begin
                    model_cfg(ri, r1v, r2v, m_vl, fok, nvl, nvt);
                    if (fok) begin
                        exp_wb = 1; exp_wb_rd = ri[11:7]; exp_wb_data = nvl;
                        m_vl = nvl; m_vtype = nvt;
                    end else begin
                        exp_ill = 1;
                    end
                end else if (f3 == 3'b001 || f3 == 3'b101 || m_vtype[31]) begin
                    exp_ill = 1;
                end else begin
                    exp_u.vd = ri[11:7]; exp_u.vs1 = ri[19:15]; exp_u.vs2 = ri[24:20];
                    exp_u.f6 = ri[31:26]; exp_u.f3 = f3; exp_u.vm = ri[25];
                    if (f3 == 3'b100 || f3 == 3'b110) exp_u.scalar = r1v;
                    else if (f3 == 3'b011) exp_u.scalar = 32'(signed'(ri[19:15]));
                    else exp_u.scalar = 0;
                    exp_u.vl = m_vl; exp_u.sew = m_vtype[5:3];
                    q.push_back(exp_u);
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
